// File: rtl/fm_wm_row_streamer_if.sv
// Element stream from the FM x WM row streamer to the adjacency-multiply stage.
interface fm_wm_row_streamer_if #(
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned FEATURE_WIDTH  = 3,
    parameter int unsigned WEIGHT_WIDTH   = 2
);
    logic [DOT_PROD_WIDTH-1:0] out_data;
    logic [FEATURE_WIDTH-1:0]  out_row;
    logic [WEIGHT_WIDTH-1:0]   out_col;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport master (
        output out_data, out_row, out_col, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_row, out_col, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/fm_wm_row_streamer.sv
// Reads the FM x WM product memory row by row, snapshots each row and
// serializes it element by element over a valid/ready stream.
module fm_wm_row_streamer #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int unsigned WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [FEATURE_WIDTH-1:0]  read_row,
    input  logic [DOT_PROD_WIDTH-1:0] fm_wm_row_in [0:WEIGHT_COLS-1],
    fm_wm_row_streamer_if.master      out_if,
    output logic                      busy,
    output logic                      done
);

    localparam logic [FEATURE_WIDTH-1:0] ROW_LAST = FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [WEIGHT_WIDTH-1:0]  COL_LAST = WEIGHT_WIDTH'(WEIGHT_COLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [FEATURE_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [WEIGHT_WIDTH-1:0]   col_cnt_q, col_cnt_d;
    logic [FEATURE_WIDTH-1:0]  read_row_q, read_row_d;
    logic [DOT_PROD_WIDTH-1:0] row_buf_q [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] row_buf_d [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] out_data_q, out_data_d;
    logic [FEATURE_WIDTH-1:0]  out_row_q, out_row_d;
    logic [WEIGHT_WIDTH-1:0]   out_col_q, out_col_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      accept;

    // Next-state, counters and registered outputs derived from the next state.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        row_buf_d = row_buf_q;
        accept    = out_valid_q & out_if.out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            LOAD: begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    row_buf_d[c] = fm_wm_row_in[c];
                end
                col_cnt_d = '0;
                state_d   = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (col_cnt_q != COL_LAST) begin
                        col_cnt_d = col_cnt_q + WEIGHT_WIDTH'(1);
                    end else if (row_cnt_q != ROW_LAST) begin
                        row_cnt_d = row_cnt_q + FEATURE_WIDTH'(1);
                        state_d   = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they follow the state being entered.
        out_valid_d = (state_d == STREAM);
        out_data_d  = '0;
        out_row_d   = '0;
        out_col_d   = '0;
        out_last_d  = 1'b0;
        if (out_valid_d) begin
            out_data_d = row_buf_d[col_cnt_d];
            out_row_d  = row_cnt_d;
            out_col_d  = col_cnt_d;
            out_last_d = (row_cnt_d == ROW_LAST) && (col_cnt_d == COL_LAST);
        end
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        read_row_d = (state_d == IDLE) ? '0 : row_cnt_d;
    end

    // State, counter, snapshot buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            read_row_q  <= '0;
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                row_buf_q[c] <= '0;
            end
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            read_row_q  <= read_row_d;
            row_buf_q   <= row_buf_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign read_row         = read_row_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_row   = out_row_q;
    assign out_if.out_col   = out_col_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/fm_wm_row_streamer.md
Name: fm_wm_row_streamer

Overview:
- Reader side of the FM×WM product memory.
- On `start`, walks `read_row` from 0 to FEATURE_ROWS-1 and snapshots each combinational row output into a local row buffer.
- Serializes each row element-by-element to a downstream consumer (adjacency-multiply stage) over a valid/ready handshake.
- Signals completion with a one-cycle `done` pulse.

Parameters:
- FEATURE_ROWS, 6, number of rows in the FM×WM memory.
- WEIGHT_COLS, 3, elements per row.
- DOT_PROD_WIDTH, 16, width of each stored product.
- FEATURE_WIDTH, $clog2(FEATURE_ROWS), row address width.
- WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column index width.

Ports:
- clk  input  1  clock; reset rst, asynchronous, active-high; clock clk.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a full-matrix read; sampled only in IDLE.
- read_row  output  FEATURE_WIDTH  row address to the product memory; registered.
- fm_wm_row_in  input  DOT_PROD_WIDTH × [0:WEIGHT_COLS-1]  combinational row data returned for read_row.
- out_data  output  DOT_PROD_WIDTH  current element.
- out_row  output  FEATURE_WIDTH  row index of out_data.
- out_col  output  WEIGHT_WIDTH  column index of out_data.
- out_valid  output  1  out_data/out_row/out_col valid.
- out_ready  input  1  consumer accepts the beat when high with out_valid.
- out_last  output  1  high with the final beat (row FEATURE_ROWS-1, col WEIGHT_COLS-1).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- **Reset:** state=IDLE; read_row, row_cnt, col_cnt=0; row buffer all 0. out_valid, out_last, busy, done=0; out_data, out_row, out_col=0. Reset asserted mid-operation aborts immediately to these values with no done pulse.
- **FSM states:** IDLE, LOAD, STREAM, DONE.
- **IDLE:**
  - start=1 → LOAD, row_cnt=0, read_row=0.
  - start=0 → stay.
- **LOAD** (exactly 1 cycle):
  - row_buf[c] <= fm_wm_row_in[c] for all c; col_cnt <= 0; → STREAM.
  - read_row equals row_cnt throughout LOAD.
- **STREAM:**
  - Outputs: out_valid=1, out_data=row_buf[col_cnt], out_row=row_cnt, out_col=col_cnt.
  - Beat accepted (out_valid & out_ready) with col_cnt<WEIGHT_COLS-1: col_cnt++.
  - Beat accepted with col_cnt=WEIGHT_COLS-1 and row_cnt<FEATURE_ROWS-1: row_cnt++, read_row++, → LOAD.
  - Beat accepted with col_cnt=WEIGHT_COLS-1 and row_cnt=FEATURE_ROWS-1: → DONE.
  - out_ready=0: hold all outputs stable; no counter change. Valid is never withdrawn before acceptance.
- **DONE:** done=1, busy=1, out_valid=0 for one cycle; → IDLE, read_row=0.
- **start handling:** start is ignored outside IDLE. start held high continuously re-launches in the cycle after DONE.
- **Snapshot semantics:** memory writes to the row currently streaming do not alter out_data. The row is snapshotted in LOAD.
- **Latency:**
  - start sampled at edge 0 → LOAD in cycle 1 → first out_valid in cycle 2.
  - With out_ready tied high, row r beats occupy cycles 2+(WEIGHT_COLS+1)r … +WEIGHT_COLS-1, i.e. one LOAD bubble per row.
- **Counters:** no wrap-around beyond FEATURE_ROWS-1 or WEIGHT_COLS-1; counters are reset to 0 on entry from IDLE.
- **Non-power-of-two sizes:** must work (e.g. 6 rows / 3 cols); unused encodings are never issued.

Test Plan:
- **Basic stream:** memory preloaded with mem[r][c]=16'h0100*r+c; pulse start, out_ready=1.
  - 18 beats in raster order with matching out_row/out_col and data.
  - First beat in cycle 2; out_last only on beat (5,2) = 16'h0502 in cycle 24.
  - done pulse in cycle 25; busy falls in cycle 26.
- **Backpressure:** deassert out_ready for 3 cycles while beat (2,1) is presented.
  - out_data=16'h0201 held stable with out_valid=1 for all 3 cycles.
  - No duplicate or skipped beats; total 18 accepted beats.
- **Snapshot:** write mem[1][2]=16'hBEEF during STREAM of row 1 after its LOAD.
  - Beat (1,2) still outputs 16'h0102.
  - A second run outputs 16'hBEEF.
- **start ignored while busy:** pulse start at beat (3,0).
  - No restart; sequence and done timing identical to the basic stream.
- **Reset mid-operation:** assert rst during beat (4,1).
  - All outputs 0 and state IDLE the same cycle; no done pulse.
  - A subsequent start streams from (0,0) correctly.
- **Random ready:** 50% random out_ready over 3 back-to-back runs with start held high.
  - Scoreboard matches all 54 beats.
  - Exactly 3 done pulses; out_last exactly 3 times.
